// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared types, constants and counter update rule for the branch predictor
//
// Contents:
//   DEFAULT_ENTRIES : default number of 2-bit predictor entries
//   ctr_t           : 2-bit counter state (SNT, WNT, WT, ST)
//   fsm_t           : controller state (IDLE, CLEAR)
//   next_state()    : counter transition for a resolved branch outcome
package bpred_pkg;

    localparam int DEFAULT_ENTRIES = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fsm_t;

    // A taken outcome jumps a weak counter straight to ST; a not-taken outcome
    // drops any counter other than ST straight to SNT.
    function automatic ctr_t next_state(input ctr_t cur, input logic taken);
        ctr_t nxt;
        nxt = cur;
        if (taken) begin
            case (cur)
                SNT:     nxt = WNT;
                default: nxt = ST;
            endcase
        end else begin
            case (cur)
                ST:      nxt = WT;
                default: nxt = SNT;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpred_table.sv
// rtl/bpred_table.sv - 2-bit counter array with one lookup port, one bypass port and one write port
//
// Ports:
//   CLK, nRST           : clock, asynchronous active-low reset (all entries to SNT)
//   rd_idx / rd_data    : combinational lookup read
//   byp_idx / byp_data  : combinational read of the entry the pending update targets
//   wr_en/wr_idx/wr_data: synchronous single-entry write
module bpred_table
    import bpred_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] rd_idx,
    output ctr_t             rd_data,
    input  logic [IDX_W-1:0] byp_idx,
    output ctr_t             byp_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  ctr_t             wr_data
);

    ctr_t mem [ENTRIES];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= SNT;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_idx];
    assign byp_data = mem[byp_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - 2-bit branch predictor controller: lookup, two-stage update, table clear
//
// Optional feature macro: BPRED_GSHARE_EN (global-history XOR indexing)
//
// Ports:
//   CLK, nRST      : clock, asynchronous active-low reset
//   lookup_pc      : fetch PC to predict
//   predict_taken  : combinational prediction for lookup_pc
//   upd_valid      : resolved-branch update strobe
//   upd_pc         : PC of the resolved branch
//   upd_taken      : actual branch outcome
//   clear_req      : one-cycle request to reinitialise the table
//   busy           : high while a clear sequence runs
module branch_predict_ctrl
    import bpred_pkg::*;
#(
    parameter int ENTRIES = DEFAULT_ENTRIES
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] lookup_pc,
    output logic        predict_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        clear_req,
    output logic        busy
);

    localparam int IDX_W = $clog2(ENTRIES);

    fsm_t             state;
    logic [IDX_W-1:0] clr_idx;
    logic             pend_valid;
    logic [IDX_W-1:0] pend_idx;
    logic             pend_taken;

    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;
    ctr_t             rd_state;
    ctr_t             byp_state;
    ctr_t             pend_next;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    ctr_t             wr_data;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                              upd_pc[31:IDX_W+2], upd_pc[1:0]};

`ifdef BPRED_GSHARE_EN
    logic [IDX_W-1:0] ghr;
    assign lookup_idx = lookup_pc[IDX_W+1:2] ^ ghr;
    assign upd_idx    = upd_pc[IDX_W+1:2] ^ ghr;
`else
    assign lookup_idx = lookup_pc[IDX_W+1:2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
`endif

    // The bypass port always points at the pending entry, so the same read
    // feeds both the table write data and the lookup forwarding path.
    assign pend_next = next_state(byp_state, pend_taken);

    bpred_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_table (
        .CLK      (CLK),
        .nRST     (nRST),
        .rd_idx   (lookup_idx),
        .rd_data  (rd_state),
        .byp_idx  (pend_idx),
        .byp_data (byp_state),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = pend_idx;
        wr_data = pend_next;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = clr_idx;
            wr_data = SNT;
        end else if (pend_valid) begin
            wr_en = 1'b1;
        end
    end

    always_comb begin
        predict_taken = rd_state[1];
        if (state == CLEAR) begin
            predict_taken = 1'b0;
        end else if (pend_valid && (lookup_idx == pend_idx)) begin
            predict_taken = pend_next[1];
        end
    end

    assign busy = (state == CLEAR);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            clr_idx    <= '0;
            pend_valid <= 1'b0;
            pend_idx   <= '0;
            pend_taken <= 1'b0;
`ifdef BPRED_GSHARE_EN
            ghr        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef BPRED_GSHARE_EN
                    if (pend_valid) begin
                        ghr <= {ghr[IDX_W-2:0], pend_taken};
                    end
`endif
                    // A clear request beats a same-cycle update; the update is lost.
                    if (clear_req) begin
                        state      <= CLEAR;
                        clr_idx    <= '0;
                        pend_valid <= 1'b0;
`ifdef BPRED_GSHARE_EN
                        ghr        <= '0;
`endif
                    end else begin
                        pend_valid <= upd_valid;
                        if (upd_valid) begin
                            pend_idx   <= upd_idx;
                            pend_taken <= upd_taken;
                        end
                    end
                end
                CLEAR: begin
                    pend_valid <= 1'b0;
                    if (clr_idx == IDX_W'(ENTRIES - 1)) begin
                        state   <= IDLE;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
